mem_access: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline. It sits between the execute stage's EX_MEM register set and write-back, and owns the data bus. Each cycle it takes the retiring EX_MEM instruction and, for loads and stores, runs a ready/wait bus transaction with byte lanes and a wait-state timeout. It stalls upstream while the transaction is pending, then registers a MEM_WB record holding the final write-back value, including load sign/zero extension and the link value for JAL/JALR.

---
 rtl/mem_access.sv | 170 +++++++++++++++++
 tb/tb_mem_access.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage of the RV32I pipeline: owns the data bus, runs ready/wait
// transactions with a wait-state timeout and registers the MEM_WB record.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction outstanding; a new access may start this cycle
// WAIT   | bus request held stable, counting wait cycles for DRDY
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    input  logic        EX_MEM_is_jal,
    input  logic        EX_MEM_is_jalr,
    output logic [31:0] DADDR,
    output logic [31:0] DATAO,
    output logic [3:0]  BE,
    output logic        RD,
    output logic        WR,
    input  logic [31:0] DATAI,
    input  logic        DRDY,
    output logic        STALL,
    output logic [31:0] MEM_WB_pc,
    output logic [31:0] MEM_WB_inst,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_data,
    output logic        MEM_WB_we,
    output logic        MEM_WB_misalign,
    output logic        MEM_WB_buserr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_mem;
    logic        aligned;
    logic        access;
    logic        misalign;
    logic        timed_out;
    logic        strobe;
    logic [3:0]  be_calc;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [31:0] wb_data;
    logic        wb_we;

    assign funct3 = EX_MEM_inst[14:12];
    assign off    = EX_MEM_alu[1:0];
    assign is_mem = (EX_MEM_is_load || EX_MEM_is_store) && (EX_MEM_inst != 32'd0);

    always_comb begin
        aligned = 1'b1;
        be_calc = 4'b1111;
        DATAO   = EX_MEM_rs2;
        case (funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_calc = 4'b0001 << off;
                DATAO   = {4{EX_MEM_rs2[7:0]}};
            end
            2'b01: begin
                aligned = ~off[0];
                be_calc = 4'b0011 << off;
                DATAO   = {2{EX_MEM_rs2[15:0]}};
            end
            default: begin
                aligned = (off == 2'b00);
                be_calc = 4'b1111;
                DATAO   = EX_MEM_rs2;
            end
        endcase
    end

    assign access   = is_mem && aligned;
    assign misalign = is_mem && !aligned;

    // Timeout is declared one cycle after the last waited cycle: the strobes
    // drop and the faulted instruction retires in that cycle.
    assign timed_out = (state == S_WAIT) && (cnt == CW'(TIMEOUT));
    assign strobe    = access && !timed_out && !RES;

    assign RD    = strobe && EX_MEM_is_load;
    assign WR    = strobe && EX_MEM_is_store;
    assign BE    = strobe ? be_calc : 4'b0000;
    assign DADDR = {EX_MEM_alu[31:2], 2'b00};
    assign STALL = strobe && !DRDY;

    always_comb begin
        lane     = DATAI >> {off, 3'b000};
        load_val = 32'd0;
        case (funct3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_val = DATAI;
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        wb_data = EX_MEM_alu;
        if (EX_MEM_is_load)
            wb_data = load_val;
        else if (EX_MEM_is_jal || EX_MEM_is_jalr)
            wb_data = EX_MEM_pc + 32'd4;
    end

    assign wb_we = (EX_MEM_inst != 32'd0) && !EX_MEM_is_store && !misalign
                   && !(timed_out && access) && (EX_MEM_rd != 5'd0);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (STALL) begin
                        state <= S_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (timed_out || !STALL) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // A stalled cycle retires a bubble so nothing is written back twice.
    always_ff @(posedge CLK) begin
        if (RES || STALL) begin
            MEM_WB_pc       <= 32'd0;
            MEM_WB_inst     <= 32'd0;
            MEM_WB_rd       <= 5'd0;
            MEM_WB_data     <= 32'd0;
            MEM_WB_we       <= 1'b0;
            MEM_WB_misalign <= 1'b0;
            MEM_WB_buserr   <= 1'b0;
        end else begin
            MEM_WB_pc       <= EX_MEM_pc;
            MEM_WB_inst     <= EX_MEM_inst;
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_data     <= wb_data;
            MEM_WB_we       <= wb_we;
            MEM_WB_misalign <= misalign;
            MEM_WB_buserr   <= timed_out && access;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: upstream driver plus bus responder, with a scoreboard
// queue of expected MEM_WB records checked by an independent monitor.
module tb_mem_access;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_jal, EX_MEM_is_jalr;
    logic [31:0] DADDR, DATAO, DATAI;
    logic [3:0]  BE;
    logic        RD, WR, DRDY, STALL;
    logic [31:0] MEM_WB_pc, MEM_WB_inst, MEM_WB_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_we, MEM_WB_misalign, MEM_WB_buserr;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst), .EX_MEM_alu(EX_MEM_alu),
        .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
        .EX_MEM_is_jal(EX_MEM_is_jal), .EX_MEM_is_jalr(EX_MEM_is_jalr),
        .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .RD(RD), .WR(WR),
        .DATAI(DATAI), .DRDY(DRDY), .STALL(STALL),
        .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_data(MEM_WB_data), .MEM_WB_we(MEM_WB_we),
        .MEM_WB_misalign(MEM_WB_misalign), .MEM_WB_buserr(MEM_WB_buserr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc, inst, data;
        logic [4:0]  rd;
        logic        we, mis, berr, chk_data;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:15], f3, r[11:7], op};
    endfunction

    // Reference load result from plain arithmetic on the addressed lane.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] di);
        logic [31:0] sh;
        sh = di >> (8 * off);
        case (f3)
            3'd0: return ((sh & 32'hFF) >= 32'd128) ? (sh & 32'hFF) - 32'd256 : (sh & 32'hFF);
            3'd1: return ((sh & 32'hFFFF) >= 32'd32768) ? (sh & 32'hFFFF) - 32'd65536 : (sh & 32'hFFFF);
            3'd2: return di;
            3'd4: return sh & 32'hFF;
            3'd5: return sh & 32'hFFFF;
            default: return 32'd0;
        endcase
    endfunction

    // cls: 0 alu, 1 load, 2 store, 3 jal, 4 jalr. w = DRDY-low cycles before DRDY.
    task automatic run_op(input int cls, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input int w, input logic [31:0] di, input logic bubble);
        logic [6:0]  op;
        logic [31:0] inst, exp_datao, exp_daddr;
        logic        ld, st, mem, aligned, access, ok, strobe_e, done;
        int          size, be_i, exp_stall, stalls, k;
        exp_t        e;
        op = (cls == 1) ? 7'h03 : (cls == 2) ? 7'h23 : (cls == 3) ? 7'h6F :
             (cls == 4) ? 7'h67 : 7'h13;
        inst = bubble ? 32'd0 : mk_inst(f3, op);
        ld = (cls == 1);
        st = (cls == 2);
        mem = (ld || st) && (inst != 0);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        aligned = ((alu[1:0] % size) == 0);
        access = mem && aligned;
        ok = (w < TO);
        be_i = (((1 << size) - 1) << alu[1:0]) & 15;
        exp_datao = (size == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
                    (size == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
        exp_daddr = alu - (alu % 4);
        exp_stall = access ? (ok ? w : TO) : 0;

        if (inst != 0) begin
            e.pc = pc; e.inst = inst; e.rd = rd;
            e.mis = mem && !aligned;
            e.berr = access && !ok;
            e.we = !st && !e.mis && !e.berr && (rd != 0);
            e.data = ld ? ref_load(f3, alu[1:0], di) : (cls == 3 || cls == 4) ? pc + 4 : alu;
            e.chk_data = !(ld && (e.mis || e.berr));
            q.push_back(e);
        end

        EX_MEM_pc = pc; EX_MEM_inst = inst; EX_MEM_alu = alu; EX_MEM_rs2 = rs2;
        EX_MEM_rd = rd; EX_MEM_is_load = ld; EX_MEM_is_store = st;
        EX_MEM_is_jal = (cls == 3); EX_MEM_is_jalr = (cls == 4);

        stalls = 0;
        k = 0;
        done = 1'b0;
        while (!done) begin
            if (access && k < TO) begin
                DRDY  = (k == w);
                DATAI = (k == w) ? di : $urandom();
            end else begin
                DRDY  = 1'($urandom_range(0, 1));
                DATAI = $urandom();
            end
            @(negedge CLK);
            strobe_e = access && (k < (ok ? w + 1 : TO));
            chk("bus_strobes", {26'd0, RD, WR, BE},
                {26'd0, strobe_e && ld, strobe_e && st, strobe_e ? 4'(be_i) : 4'd0});
            if (strobe_e) chk("daddr", DADDR, exp_daddr);
            if (strobe_e && st) chk("datao", DATAO, exp_datao);
            if (STALL) stalls++;
            done = !STALL;
            @(posedge CLK);
            #1;
            k++;
            if (!done && k > 40) begin
                chk("stall_bound", 32'(k), 32'(exp_stall));
                done = 1'b1;
            end
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    always @(negedge CLK) begin
        if (!RES) begin
            if (MEM_WB_inst != 32'd0) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", MEM_WB_inst, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_pc", MEM_WB_pc, e.pc);
                    chk("wb_inst", MEM_WB_inst, e.inst);
                    chk("wb_ctrl", {24'd0, 3'd0, MEM_WB_rd}, {24'd0, 3'd0, e.rd});
                    chk("wb_flags", {29'd0, MEM_WB_we, MEM_WB_misalign, MEM_WB_buserr},
                        {29'd0, e.we, e.mis, e.berr});
                    if (e.chk_data) chk("wb_data", MEM_WB_data, e.data);
                end
            end else if (MEM_WB_we || MEM_WB_misalign || MEM_WB_buserr) begin
                chk("bubble_flags", {29'd0, MEM_WB_we, MEM_WB_misalign, MEM_WB_buserr}, 32'd0);
            end
        end
    end

    initial begin
        RES = 1'b1;
        EX_MEM_pc = 32'h80000000; EX_MEM_inst = mk_inst(3'd2, 7'h03);
        EX_MEM_alu = 32'h00001000; EX_MEM_rs2 = 32'd0; EX_MEM_rd = 5'd1;
        EX_MEM_is_load = 1'b1; EX_MEM_is_store = 1'b0;
        EX_MEM_is_jal = 1'b0; EX_MEM_is_jalr = 1'b0;
        DATAI = 32'd0; DRDY = 1'b0;

        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_strobes", {27'd0, RD, WR, STALL, (BE != 0)}, 32'd0);
        chk("rst_mwb", MEM_WB_pc | MEM_WB_inst | MEM_WB_data |
            {24'd0, MEM_WB_rd, MEM_WB_we, MEM_WB_misalign, MEM_WB_buserr}, 32'd0);
        @(posedge CLK); #1;
        RES = 1'b0;

        // Directed cases
        run_op(2, 3'd0, 32'h80000000, 32'h80000103, 32'h000000AB, 5'd9, 0, 32'd0, 1'b0);
        run_op(1, 3'd0, 32'h80000004, 32'h00000202, 32'd0, 5'd3, 0, 32'h00800000, 1'b0);
        run_op(1, 3'd4, 32'h80000008, 32'h00000202, 32'd0, 5'd3, 0, 32'h00800000, 1'b0);
        run_op(1, 3'd1, 32'h8000000C, 32'h00000202, 32'd0, 5'd4, 0, 32'h8001FFFF, 1'b0);
        run_op(1, 3'd2, 32'h80000010, 32'h00000400, 32'd0, 5'd7, 3, 32'h12345678, 1'b0);
        run_op(1, 3'd2, 32'h80000014, 32'h00000404, 32'd0, 5'd8, 99, 32'hDEADBEEF, 1'b0);
        run_op(1, 3'd2, 32'h80000018, 32'h00000102, 32'd0, 5'd5, 0, 32'h11111111, 1'b0);
        run_op(3, 3'd0, 32'h80000010, 32'h00000000, 32'd0, 5'd1, 0, 32'd0, 1'b0);
        run_op(0, 3'd0, 32'h80000020, 32'h00000055, 32'd0, 5'd0, 0, 32'd0, 1'b0);
        run_op(2, 3'd1, 32'h80000024, 32'h00000302, 32'h0000BEEF, 5'd2, 1, 32'd0, 1'b0);
        run_op(1, 3'd5, 32'h80000028, 32'h00000302, 32'd0, 5'd6, 2, 32'hF00DCAFE, 1'b0);
        run_op(1, 3'd2, 32'h8000002C, 32'h00000500, 32'd0, 5'd6, TO - 1, 32'hCAFEF00D, 1'b0);

        // Reset in the second cycle of a stalled load
        EX_MEM_pc = 32'h80000030; EX_MEM_inst = mk_inst(3'd2, 7'h03);
        EX_MEM_alu = 32'h00000600; EX_MEM_rd = 5'd5;
        EX_MEM_is_load = 1'b1; EX_MEM_is_store = 1'b0;
        EX_MEM_is_jal = 1'b0; EX_MEM_is_jalr = 1'b0;
        DRDY = 1'b0;
        @(negedge CLK);
        chk("pre_rst_stall", {30'd0, RD, STALL}, 32'd3);
        @(posedge CLK); #1;
        RES = 1'b1;
        @(negedge CLK);
        chk("midwait_rst", {29'd0, RD, STALL, (BE != 0)}, 32'd0);
        @(posedge CLK); #1;
        chk("midwait_mwb", MEM_WB_pc | MEM_WB_inst | MEM_WB_data |
            {24'd0, MEM_WB_rd, MEM_WB_we, MEM_WB_misalign, MEM_WB_buserr}, 32'd0);
        RES = 1'b0;
        EX_MEM_inst = 32'd0;
        DRDY = 1'b1;
        DATAI = 32'h12345678;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("no_late_retire", {MEM_WB_inst[30:0], MEM_WB_we}, 32'd0);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 250; i++) begin
            int cls, w;
            logic [2:0] f3;
            logic [31:0] alu;
            cls = $urandom_range(0, 4);
            f3  = (cls == 1) ? 3'($urandom_range(0, 7)) :
                  (cls == 2) ? 3'($urandom_range(0, 2)) : 3'd0;
            alu = $urandom();
            w   = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, TO);
            run_op(cls, f3, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, alu, $urandom(),
                   5'($urandom_range(0, 31)), w, $urandom(), ($urandom_range(0, 9) == 0));
        end

        EX_MEM_inst = 32'd0;
        EX_MEM_is_load = 1'b0;
        EX_MEM_is_store = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
